fetch_stage: RTL and testbench

Instruction-fetch front end of the RISC-V core: owns the program counter, drives a synchronous-read instruction memory, and presents `{pc, instr}` pairs to the decode stage through a valid/ready handshake. A 2-entry holding buffer absorbs the one-cycle memory latency, so decode back-pressure never drops or duplicates an instruction. Branch/jump redirects from execute flush everything in flight and restart fetch at the target.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/fetch_stage_if.sv | 13 +
 rtl/fetch_skid_buffer.sv | 61 ++++++
 rtl/fetch_stage.sv | 83 ++++++++
 tb/tb_fetch_stage.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch widths, reset constants and the fetch packet type
package riscv_pkg;

    localparam int PC_WIDTH    = 16;
    localparam int INSTR_WIDTH = 32;

    localparam logic [PC_WIDTH-1:0]    RESET_PC  = 16'h0000;
    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_pkt_t;

    function automatic logic [PC_WIDTH-1:0] word_align(input logic [PC_WIDTH-1:0] addr);
        return {addr[PC_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch-to-decode valid/ready handshake carrying {pc, instr}
interface fetch_stage_if;
    import riscv_pkg::*;

    logic                   if_valid;
    logic                   if_ready;
    logic [PC_WIDTH-1:0]    if_pc;
    logic [INSTR_WIDTH-1:0] if_instr;

    modport master (output if_valid, output if_pc, output if_instr, input if_ready);
    modport slave  (input if_valid, input if_pc, input if_instr, output if_ready);

endinterface

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - 2-entry in-order holding buffer; head entry is the decode output register
module fetch_skid_buffer
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  fetch_pkt_t push_pkt,
    input  logic       pop,
    input  logic       flush,
    output logic       head_valid,
    output fetch_pkt_t head_pkt,
    output logic       full,
    output logic       empty,
    output logic [1:0] count
);

    logic       skid_valid;
    fetch_pkt_t skid_pkt;
    logic       pop_eff;

    assign pop_eff = pop & head_valid;
    assign full    = head_valid & skid_valid;
    assign empty   = ~head_valid;
    assign count   = {1'b0, head_valid} + {1'b0, skid_valid};

    // Entries fill head first, so skid_valid implies head_valid and order is preserved.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
            head_pkt   <= '{pc: '0, instr: NOP_INSTR};
            skid_pkt   <= '{pc: '0, instr: NOP_INSTR};
        end else if (flush) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (pop_eff) begin
            if (skid_valid) begin
                head_pkt <= skid_pkt;
                if (push) begin
                    skid_pkt <= push_pkt;
                end else begin
                    skid_valid <= 1'b0;
                end
            end else if (push) begin
                head_pkt <= push_pkt;
            end else begin
                head_valid <= 1'b0;
            end
        end else if (push) begin
            if (!head_valid) begin
                head_pkt   <= push_pkt;
                head_valid <= 1'b1;
            end else if (!skid_valid) begin
                skid_pkt   <= push_pkt;
                skid_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, imem issue control and inflight tracking feeding the decode handshake
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_en,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    fetch_stage_if.master          dec,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [PC_WIDTH-1:0]    pc_next
);

    logic                inflight;
    logic [PC_WIDTH-1:0] inflight_pc;
    logic                fire;
    logic [2:0]          occ;
    logic                buf_valid;
    fetch_pkt_t          head_pkt;
    fetch_pkt_t          ret_pkt;
    logic                buf_full;
    logic                buf_empty;
    logic [1:0]          buf_count;

    assign fire    = buf_valid & dec.if_ready;
    assign occ     = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, fire};
    assign ret_pkt = '{pc: inflight_pc, instr: imem_rdata};

    // An outstanding request already owns a slot, so issue only while a slot is left.
    assign imem_en   = ~rst & ~redirect_valid & (occ < 3'd2);
    assign imem_addr = pc;

    always_comb begin
        pc_next = pc;
        if (rst) begin
            pc_next = RESET_PC;
        end else if (redirect_valid) begin
            pc_next = word_align(redirect_pc);
        end else if (imem_en) begin
            pc_next = pc + PC_WIDTH'(4);
        end
    end

    always_ff @(posedge clk) begin
        pc <= pc_next;
        if (rst) begin
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= imem_en;
            if (imem_en) begin
                inflight_pc <= pc;
            end
        end
    end

    fetch_skid_buffer u_skid (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight),
        .push_pkt   (ret_pkt),
        .pop        (fire),
        .flush      (redirect_valid),
        .head_valid (buf_valid),
        .head_pkt   (head_pkt),
        .full       (buf_full),
        .empty      (buf_empty),
        .count      (buf_count)
    );

    assign dec.if_valid = ~buf_empty;
    assign dec.if_pc    = head_pkt.pc;
    assign dec.if_instr = head_pkt.instr;

    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(inflight && buf_full && !fire && !redirect_valid));

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;
    import riscv_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   redirect_valid;
    logic [PC_WIDTH-1:0]    redirect_pc;

    logic                   imem_en_a, imem_en_b;
    logic [PC_WIDTH-1:0]    imem_addr_a, imem_addr_b;
    logic [INSTR_WIDTH-1:0] imem_rdata_a, imem_rdata_b;
    logic [PC_WIDTH-1:0]    pc_a, pc_b, pc_next_a, pc_next_b;

    int tests_run    = 0;
    int tests_failed = 0;
    int n_pc20       = 0;
    int n_pc24       = 0;

    fetch_stage_if dec_a ();
    fetch_stage_if dec_b ();

    always #5 clk = ~clk;

    fetch_stage dut_a (
        .clk            (clk),
        .rst            (rst),
        .imem_en        (imem_en_a),
        .imem_addr      (imem_addr_a),
        .imem_rdata     (imem_rdata_a),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec            (dec_a),
        .pc             (pc_a),
        .pc_next        (pc_next_a)
    );

    fetch_stage #(.RESET_PC(16'hFFF8)) dut_b (
        .clk            (clk),
        .rst            (rst),
        .imem_en        (imem_en_b),
        .imem_addr      (imem_addr_b),
        .imem_rdata     (imem_rdata_b),
        .redirect_valid (1'b0),
        .redirect_pc    (16'h0000),
        .dec            (dec_b),
        .pc             (pc_b),
        .pc_next        (pc_next_b)
    );

    // Memory word i holds the value i.
    always @(posedge clk) begin
        if (imem_en_a) imem_rdata_a <= {16'h0000, imem_addr_a} >> 2;
        if (imem_en_b) imem_rdata_b <= {16'h0000, imem_addr_b} >> 2;
    end

    always @(posedge clk) begin
        if (dec_a.if_valid && dec_a.if_ready && dec_a.if_pc == 16'd20) n_pc20 <= n_pc20 + 1;
        if (dec_a.if_valid && dec_a.if_ready && dec_a.if_pc == 16'd24) n_pc24 <= n_pc24 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out_a(input string tag, input logic [15:0] exp_pc, input logic [31:0] exp_instr);
        check({tag, "_valid"}, 32'(dec_a.if_valid), 32'd1);
        check({tag, "_pc"}, 32'(dec_a.if_pc), 32'(exp_pc));
        check({tag, "_instr"}, dec_a.if_instr, exp_instr);
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_a.if_ready = 1'b0;
        dec_b.if_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        check("rst_valid", 32'(dec_a.if_valid), 32'd0);
        check("rst_pc", 32'(pc_a), 32'h0000);
        check("rst_pc_next", 32'(pc_next_a), 32'h0000);
        check("rst_imem_en", 32'(imem_en_a), 32'd0);
        check("rst_if_pc", 32'(dec_a.if_pc), 32'h0000);
        check("rst_if_instr", dec_a.if_instr, 32'h00000013);
        check("rst_pc_b", 32'(pc_b), 32'h0000FFF8);

        rst            = 1'b0;
        dec_a.if_ready = 1'b1;
        #1;
        check("c0_imem_en", 32'(imem_en_a), 32'd1);
        check("c0_imem_addr", 32'(imem_addr_a), 32'h0000);
        check("c0_imem_addr_b", 32'(imem_addr_b), 32'h0000FFF8);
        tick;
        check("c1_valid", 32'(dec_a.if_valid), 32'd0);
        tick;
        check_out_a("c2", 16'h0000, 32'd0);
        check("c2_b_pc", 32'(dec_b.if_pc), 32'h0000FFF8);
        check("c2_b_instr", dec_b.if_instr, 32'h00003FFE);
        tick;
        check_out_a("c3", 16'h0004, 32'd1);
        check("c3_b_pc", 32'(dec_b.if_pc), 32'h0000FFFC);
        tick;
        check_out_a("c4", 16'h0008, 32'd2);
        check("c4_b_pc", 32'(dec_b.if_pc), 32'h00000000);

        dec_a.if_ready = 1'b0;
        #1;
        check("stall_en0", 32'(imem_en_a), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            tick;
            check_out_a("stall", 16'h0008, 32'd2);
            check("stall_en", 32'(imem_en_a), 32'd0);
            if (i == 1) check("c5_b_pc", 32'(dec_b.if_pc), 32'h00000004);
        end

        dec_a.if_ready = 1'b1;
        #1;
        check("release_en", 32'(imem_en_a), 32'd1);
        check_out_a("rel0", 16'h0008, 32'd2);
        tick;
        check_out_a("rel1", 16'h000C, 32'd3);
        tick;
        check_out_a("rel2", 16'h0010, 32'd4);
        tick;
        check_out_a("rel3", 16'h0014, 32'd5);

        redirect_valid = 1'b1;
        redirect_pc    = 16'h0103;
        #1;
        check("redir_en", 32'(imem_en_a), 32'd0);
        check("redir_pc_next", 32'(pc_next_a), 32'h0100);
        tick;
        redirect_valid = 1'b0;
        #1;
        check("redir_t1_valid", 32'(dec_a.if_valid), 32'd0);
        check("redir_t1_pc", 32'(pc_a), 32'h0100);
        check("redir_t1_en", 32'(imem_en_a), 32'd1);
        check("redir_t1_addr", 32'(imem_addr_a), 32'h0100);
        tick;
        check("redir_t2_valid", 32'(dec_a.if_valid), 32'd0);
        tick;
        check_out_a("redir_t3", 16'h0100, 32'h40);
        tick;
        check_out_a("redir_t4", 16'h0104, 32'h41);
        check("pc20_once", 32'(n_pc20), 32'd1);
        check("pc24_never", 32'(n_pc24), 32'd0);

        dec_a.if_ready = 1'b0;
        repeat (3) tick;
        check("midstall_en", 32'(imem_en_a), 32'd0);
        check_out_a("midstall", 16'h0104, 32'h41);

        rst = 1'b1;
        #1;
        check("rst2_en", 32'(imem_en_a), 32'd0);
        check("rst2_pc_next", 32'(pc_next_a), 32'h0000);
        tick;
        rst            = 1'b0;
        dec_a.if_ready = 1'b1;
        #1;
        check("rst2_valid", 32'(dec_a.if_valid), 32'd0);
        check("rst2_pc", 32'(pc_a), 32'h0000);
        check("rst2_c0_en", 32'(imem_en_a), 32'd1);
        check("rst2_c0_addr", 32'(imem_addr_a), 32'h0000);
        tick;
        check("rst2_c1_valid", 32'(dec_a.if_valid), 32'd0);
        tick;
        check_out_a("rst2_c2", 16'h0000, 32'd0);
        tick;
        check_out_a("rst2_c3", 16'h0004, 32'd1);
        check("pc24_never_end", 32'(n_pc24), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
